dct8_1d_pipe: RTL and testbench

Pipelined, parameterised 8-point 1-D integer transform engine for the 8x8 transform path. Each beat processes one row or column of eight signed samples in either forward (integer DCT) or inverse (integer IDCT) mode, selected per beat. Three register stages give full throughput with a single stall-all valid/ready handshake. It replaces the purely combinational 8-point forward kernel as the building block for the row/column passes of the 2-D transform.

---
 rtl/dct8_pkg.sv | 23 ++
 rtl/dct8_stage_reg.sv | 36 +++
 rtl/dct8_1d_pipe.sv | 172 +++++++++++++++++
 tb/tb_dct8_1d_pipe.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dct8_pkg.sv
// Shared constants and lane helpers for the 8-point transform engine.
// Mode encodings, lane count, lane offset and sign-extension functions.
package dct8_pkg;

   localparam logic DCT_MODE_FWD = 1'b0;
   localparam logic DCT_MODE_INV = 1'b1;
   localparam int   DCT_LANES    = 8;
   localparam int   DCT_MAX_W    = 32;

   // LSB position of lane k in a bus of w-bit lanes
   function automatic int lane_lsb(input int k, input int w);
      return k * w;
   endfunction

   // Sign-extend the low w bits of raw to DCT_MAX_W bits
   function automatic logic signed [DCT_MAX_W-1:0] lane_sext(
      input logic [DCT_MAX_W-1:0] raw,
      input int                   w
   );
      return $signed(raw << (DCT_MAX_W - w)) >>> (DCT_MAX_W - w);
   endfunction

endpackage

// File: rtl/dct8_stage_reg.sv
// Enable-gated pipeline register: valid, mode, tag and 8 data lanes.
// Ports: clk, rst_n, en, d_valid/d_mode/d_tag/d_data in, q_* out.
module dct8_stage_reg
   import dct8_pkg::*;
#(
   parameter int OUT_WIDTH = 12,
   parameter int TAG_WIDTH = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           en,
   input  logic                           d_valid,
   input  logic                           d_mode,
   input  logic [TAG_WIDTH-1:0]           d_tag,
   input  logic [DCT_LANES*OUT_WIDTH-1:0] d_data,
   output logic                           q_valid,
   output logic                           q_mode,
   output logic [TAG_WIDTH-1:0]           q_tag,
   output logic [DCT_LANES*OUT_WIDTH-1:0] q_data
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_valid <= 1'b0;
         q_mode  <= 1'b0;
         q_tag   <= '0;
         q_data  <= '0;
      end else if (en) begin
         q_valid <= d_valid;
         q_mode  <= d_mode;
         q_tag   <= d_tag;
         q_data  <= d_data;
      end
   end

endmodule

// File: rtl/dct8_1d_pipe.sv
// Three-stage 8-point forward/inverse integer transform, stall-all.
// Ports: clk, rst_n, in_valid/ready/mode/tag/data, out_valid/ready/mode/tag/data.
module dct8_1d_pipe
   import dct8_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int OUT_WIDTH  = DATA_WIDTH + 4,
   parameter int TAG_WIDTH  = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic                            in_mode,
   input  logic [TAG_WIDTH-1:0]            in_tag,
   input  logic [DCT_LANES*DATA_WIDTH-1:0] in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            out_mode,
   output logic [TAG_WIDTH-1:0]            out_tag,
   output logic [DCT_LANES*OUT_WIDTH-1:0]  out_data
);

   localparam int BW = DCT_LANES * OUT_WIDTH;

   typedef logic signed [OUT_WIDTH-1:0] lane_t;

   logic                 en;
   logic                 s1_v, s2_v;
   logic                 s1_m, s2_m;
   logic [TAG_WIDTH-1:0] s1_t, s2_t;
   logic [BW-1:0]        s1_d, s2_d;
   logic [BW-1:0]        s1_n, s2_n, s3_n;

   lane_t x1 [DCT_LANES];
   lane_t x2 [DCT_LANES];
   lane_t x3 [DCT_LANES];
   lane_t r1 [DCT_LANES];
   lane_t r2 [DCT_LANES];
   lane_t r3 [DCT_LANES];

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   for (genvar k = 0; k < DCT_LANES; k++) begin : g_lane
      localparam int LI = lane_lsb(k, DATA_WIDTH);
      localparam int LO = lane_lsb(k, OUT_WIDTH);
      assign x1[k] = lane_t'(lane_sext(
                        DCT_MAX_W'(in_data[LI +: DATA_WIDTH]),
                        DATA_WIDTH));
      assign x2[k] = lane_t'(s1_d[LO +: OUT_WIDTH]);
      assign x3[k] = lane_t'(s2_d[LO +: OUT_WIDTH]);
      assign s1_n[LO +: OUT_WIDTH] = r1[k];
      assign s2_n[LO +: OUT_WIDTH] = r2[k];
      assign s3_n[LO +: OUT_WIDTH] = r3[k];
   end

   // Stage 1: forward butterflies or inverse even/odd split
   always_comb begin
      for (int k = 0; k < DCT_LANES; k++) r1[k] = '0;
      if (in_mode == DCT_MODE_INV) begin
         r1[0] = x1[0] + x1[4];
         r1[4] = x1[0] - x1[4];
         r1[2] = (x1[2] >>> 1) - x1[6];
         r1[6] = x1[2] + (x1[6] >>> 1);
         r1[1] = -x1[3] + x1[5] - x1[7] - (x1[7] >>> 1);
         r1[3] = x1[1] + x1[7] - x1[3] - (x1[3] >>> 1);
         r1[5] = -x1[1] + x1[7] + x1[5] + (x1[5] >>> 1);
         r1[7] = x1[3] + x1[5] + x1[1] + (x1[1] >>> 1);
      end else begin
         r1[0] = x1[0] + x1[7];
         r1[1] = x1[3] - x1[4];
         r1[2] = x1[1] + x1[6];
         r1[3] = x1[2] - x1[5];
         r1[4] = x1[2] + x1[5];
         r1[5] = x1[1] - x1[6];
         r1[6] = x1[3] + x1[4];
         r1[7] = x1[0] - x1[7];
      end
   end

   // Stage 2: second butterfly layer with quarter-weight rotations
   always_comb begin
      for (int k = 0; k < DCT_LANES; k++) r2[k] = '0;
      if (s1_m == DCT_MODE_INV) begin
         r2[0] = x2[0] + x2[6];
         r2[2] = x2[4] + x2[2];
         r2[4] = x2[4] - x2[2];
         r2[6] = x2[0] - x2[6];
         r2[1] = x2[1] + (x2[7] >>> 2);
         r2[7] = x2[7] - (x2[1] >>> 2);
         r2[3] = x2[3] + (x2[5] >>> 2);
         r2[5] = (x2[3] >>> 2) - x2[5];
      end else begin
         r2[0] = x2[0] + x2[6];
         r2[1] = x2[1] - (x2[7] >>> 2);
         r2[2] = x2[2] + x2[4];
         r2[3] = x2[3] + (x2[5] >>> 2);
         r2[4] = x2[2] - x2[4];
         r2[5] = (x2[3] >>> 2) - x2[5];
         r2[6] = x2[0] - x2[6];
         r2[7] = (x2[1] >>> 2) + x2[7];
      end
   end

   // Stage 3: output combination
   always_comb begin
      for (int k = 0; k < DCT_LANES; k++) r3[k] = '0;
      if (s2_m == DCT_MODE_INV) begin
         r3[0] = x3[0] + x3[7];
         r3[1] = x3[2] + x3[5];
         r3[2] = x3[4] + x3[3];
         r3[3] = x3[6] + x3[1];
         r3[4] = x3[6] - x3[1];
         r3[5] = x3[4] - x3[3];
         r3[6] = x3[2] - x3[5];
         r3[7] = x3[0] - x3[7];
      end else begin
         r3[0] = x3[0] + x3[2];
         r3[1] = x3[3] - x3[5] + x3[7] + (x3[7] >>> 1);
         r3[2] = (x3[4] >>> 1) + x3[6];
         r3[3] = -x3[1] - x3[3] - (x3[3] >>> 1) + x3[7];
         r3[4] = x3[0] - x3[2];
         r3[5] = x3[1] + x3[5] + (x3[5] >>> 1) + x3[7];
         r3[6] = -x3[4] + (x3[6] >>> 1);
         r3[7] = -x3[1] - (x3[1] >>> 1) + x3[3] + x3[5];
      end
   end

   dct8_stage_reg #(.OUT_WIDTH(OUT_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_s1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .d_valid (in_valid),
      .d_mode  (in_mode),
      .d_tag   (in_tag),
      .d_data  (s1_n),
      .q_valid (s1_v),
      .q_mode  (s1_m),
      .q_tag   (s1_t),
      .q_data  (s1_d)
   );

   dct8_stage_reg #(.OUT_WIDTH(OUT_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_s2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .d_valid (s1_v),
      .d_mode  (s1_m),
      .d_tag   (s1_t),
      .d_data  (s2_n),
      .q_valid (s2_v),
      .q_mode  (s2_m),
      .q_tag   (s2_t),
      .q_data  (s2_d)
   );

   dct8_stage_reg #(.OUT_WIDTH(OUT_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_s3 (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .d_valid (s2_v),
      .d_mode  (s2_m),
      .d_tag   (s2_t),
      .d_data  (s3_n),
      .q_valid (out_valid),
      .q_mode  (out_mode),
      .q_tag   (out_tag),
      .q_data  (out_data)
   );

endmodule

// File: tb/tb_dct8_1d_pipe.sv
// Self-checking bench for dct8_1d_pipe against an integer reference model.
// Directed vectors, back-to-back mixed modes, stalls, random traffic, reset.
module tb_dct8_1d_pipe;

   localparam int DW = 8;
   localparam int OW = 12;
   localparam int TW = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic            in_mode = 1'b0;
   logic [TW-1:0]   in_tag = '0;
   logic [8*DW-1:0] in_data = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic            out_mode;
   logic [TW-1:0]   out_tag;
   logic [8*OW-1:0] out_data;

   typedef struct packed {
      logic            m;
      logic [TW-1:0]   t;
      logic [8*OW-1:0] d;
   } beat_t;

   beat_t exp_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   int    n_out   = 0;

   always #5 clk = ~clk;

   dct8_1d_pipe #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .TAG_WIDTH(TW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_tag    (in_tag),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_mode  (out_mode),
      .out_tag   (out_tag),
      .out_data  (out_data)
   );

   task automatic check(input string tag, input logic [127:0] obs,
                        input logic [127:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic [8*OW-1:0] golden(input logic m,
                                              input logic [8*DW-1:0] d);
      int x[8];
      int s[8];
      int t[8];
      int o[8];
      for (int k = 0; k < 8; k++) x[k] = int'($signed(d[k*DW +: DW]));
      if (!m) begin
         s[0] = x[0] + x[7]; s[1] = x[3] - x[4];
         s[2] = x[1] + x[6]; s[3] = x[2] - x[5];
         s[4] = x[2] + x[5]; s[5] = x[1] - x[6];
         s[6] = x[3] + x[4]; s[7] = x[0] - x[7];
         t[0] = s[0] + s[6]; t[1] = s[1] - (s[7] >>> 2);
         t[2] = s[2] + s[4]; t[3] = s[3] + (s[5] >>> 2);
         t[4] = s[2] - s[4]; t[5] = (s[3] >>> 2) - s[5];
         t[6] = s[0] - s[6]; t[7] = (s[1] >>> 2) + s[7];
         o[0] = t[0] + t[2];
         o[1] = t[3] - t[5] + t[7] + (t[7] >>> 1);
         o[2] = (t[4] >>> 1) + t[6];
         o[3] = -t[1] - t[3] - (t[3] >>> 1) + t[7];
         o[4] = t[0] - t[2];
         o[5] = t[1] + t[5] + (t[5] >>> 1) + t[7];
         o[6] = -t[4] + (t[6] >>> 1);
         o[7] = -t[1] - (t[1] >>> 1) + t[3] + t[5];
      end else begin
         s[0] = x[0] + x[4]; s[4] = x[0] - x[4];
         s[2] = (x[2] >>> 1) - x[6]; s[6] = x[2] + (x[6] >>> 1);
         s[1] = -x[3] + x[5] - x[7] - (x[7] >>> 1);
         s[3] = x[1] + x[7] - x[3] - (x[3] >>> 1);
         s[5] = -x[1] + x[7] + x[5] + (x[5] >>> 1);
         s[7] = x[3] + x[5] + x[1] + (x[1] >>> 1);
         t[0] = s[0] + s[6]; t[2] = s[4] + s[2];
         t[4] = s[4] - s[2]; t[6] = s[0] - s[6];
         t[1] = s[1] + (s[7] >>> 2); t[7] = s[7] - (s[1] >>> 2);
         t[3] = s[3] + (s[5] >>> 2); t[5] = (s[3] >>> 2) - s[5];
         o[0] = t[0] + t[7]; o[1] = t[2] + t[5];
         o[2] = t[4] + t[3]; o[3] = t[6] + t[1];
         o[4] = t[6] - t[1]; o[5] = t[4] - t[3];
         o[6] = t[2] - t[5]; o[7] = t[0] - t[7];
      end
      golden = '0;
      for (int k = 0; k < 8; k++) golden[k*OW +: OW] = o[k][OW-1:0];
   endfunction

   function automatic logic [8*OW-1:0] pk8(input int a0, input int a1,
      input int a2, input int a3, input int a4, input int a5,
      input int a6, input int a7);
      int v[8];
      v = '{a0, a1, a2, a3, a4, a5, a6, a7};
      pk8 = '0;
      for (int k = 0; k < 8; k++) pk8[k*OW +: OW] = v[k][OW-1:0];
   endfunction

   function automatic logic [8*DW-1:0] fill(input int v);
      fill = '0;
      for (int k = 0; k < 8; k++) fill[k*DW +: DW] = v[DW-1:0];
   endfunction

   function automatic logic [8*DW-1:0] rnd_data();
      return {$urandom, $urandom};
   endfunction

   // One cycle: drive, score output and input handshakes, advance
   task automatic step(input logic v, input logic m, input logic [TW-1:0] t,
                       input logic [8*DW-1:0] d, input logic ordy);
      beat_t b;
      in_valid  = v;
      in_mode   = m;
      in_tag    = t;
      in_data   = d;
      out_ready = ordy;
      #2;
      if (out_valid && ordy) begin
         n_out++;
         if (exp_q.size() == 0) begin
            check("unexpected_out", 128'(out_valid), 128'(0));
         end else begin
            b = exp_q.pop_front();
            check("out_beat", 128'({out_mode, out_tag, out_data}), 128'(b));
         end
      end
      if (v && in_ready) begin
         b.m = m;
         b.t = t;
         b.d = golden(m, d);
         exp_q.push_back(b);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++)
         step(1'b0, 1'b0, '0, '0, 1'b1);
      check(tag, 128'(exp_q.size()), 128'(0));
   endtask

   task automatic directed(input string tag, input logic m,
                           input logic [TW-1:0] t, input logic [8*DW-1:0] d,
                           input logic [8*OW-1:0] expd);
      step(1'b1, m, t, d, 1'b1);
      step(1'b0, 1'b0, '0, '0, 1'b1);
      check({tag, "_early"}, 128'(out_valid), 128'(0));
      step(1'b0, 1'b0, '0, '0, 1'b1);
      check({tag, "_valid"}, 128'(out_valid), 128'(1));
      check({tag, "_beat"}, 128'({out_mode, out_tag, out_data}),
            128'({m, t, expd}));
      step(1'b0, 1'b0, '0, '0, 1'b1);
   endtask

   initial begin
      logic [8*OW-1:0] held;
      int              base;

      #12;
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_out_mode", 128'(out_mode), 128'(0));
      check("rst_out_tag", 128'(out_tag), 128'(0));
      check("rst_out_data", 128'(out_data), 128'(0));
      check("rst_in_ready", 128'(in_ready), 128'(1));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      directed("fwd_ones", 1'b0, 4'h5, fill(1), pk8(8, 0, 0, 0, 0, 0, 0, 0));
      directed("fwd_imp", 1'b0, 4'h9, 64'h1,
               pk8(1, 1, 1, 1, 1, 1, 0, 0));
      directed("inv_dc", 1'b1, 4'hc, 64'h8,
               pk8(8, 8, 8, 8, 8, 8, 8, 8));
      directed("fwd_min", 1'b0, 4'h3, fill(-128),
               pk8(-1024, 0, 0, 0, 0, 0, 0, 0));

      base = n_out;
      for (int i = 0; i < 16; i++)
         step(1'b1, 1'(i), TW'(i), rnd_data(), 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, 1'b1);
      check("b2b_count", 128'(n_out - base), 128'(16));
      check("b2b_empty", 128'(exp_q.size()), 128'(0));

      for (int i = 0; i < 3; i++)
         step(1'b1, 1'(i + 1), TW'(i + 2), rnd_data(), 1'b1);
      check("stall_full", 128'(out_valid), 128'(1));
      held = out_data;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 4'hf, rnd_data(), 1'b0);
         check("stall_in_ready", 128'(in_ready), 128'(0));
         check("stall_hold", 128'(out_data), 128'(held));
      end
      check("stall_q_depth", 128'(exp_q.size()), 128'(3));
      drain("stall_drain");

      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              TW'($urandom), rnd_data(), 1'($urandom_range(0, 3) != 0));
      drain("rand_drain");

      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b0, TW'(i), rnd_data(), 1'b1);
      step(1'b0, 1'b0, '0, '0, 1'b0);
      step(1'b0, 1'b0, '0, '0, 1'b0);
      check("pre_rst_valid", 128'(out_valid), 128'(1));
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 128'(out_valid), 128'(0));
      check("async_rst_data", 128'(out_data), 128'(0));
      exp_q.delete();
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, 1'b1);
      check("post_rst_idle", 128'(out_valid), 128'(0));
      directed("post_rst_fwd", 1'b0, 4'h7, 64'h1,
               pk8(1, 1, 1, 1, 1, 1, 0, 0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
